// File: rtl/regfile_wb_driver_if.sv
// Bundle between the writeback producers, the register-file write port and the hazard unit.
// The driver connects through the slave modport; the environment uses master.
interface regfile_wb_driver_if #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_reg;
    logic [DATA_W-1:0] alu_data;
    logic              md_valid;
    logic              md_ready;
    logic [ADDR_W-1:0] md_reg;
    logic [DATA_W-1:0] md_data;
    logic [ADDR_W-1:0] writeReg;
    logic [DATA_W-1:0] writeData;
    logic              RegWrite;
    logic [ADDR_W-1:0] chk_regA;
    logic [ADDR_W-1:0] chk_regB;
    logic              busyA;
    logic              busyB;
    logic [CW-1:0]     count;

    modport slave (
        input  alu_valid, alu_reg, alu_data, md_valid, md_reg, md_data, chk_regA, chk_regB,
        output alu_ready, md_ready, writeReg, writeData, RegWrite, busyA, busyB, count
    );

    modport master (
        output alu_valid, alu_reg, alu_data, md_valid, md_reg, md_data, chk_regA, chk_regB,
        input  alu_ready, md_ready, writeReg, writeData, RegWrite, busyA, busyB, count
    );
endinterface

// File: rtl/regfile_wb_driver.sv
// In-order writeback FIFO feeding the register file's single write port, one retire per clock,
// with per-register pending-write status for the hazard unit.
module regfile_wb_driver #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_wb_driver_if.slave   bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int PW = $clog2(DEPTH);

    logic [ADDR_W-1:0] r_reg  [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [DEPTH-1:0]  r_vld;
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;
    logic [ADDR_W-1:0] r_wreg;
    logic [DATA_W-1:0] r_wdata;
    logic              r_we;

    logic              w_alu_ready;
    logic              w_md_ready;
    logic              w_alu_acc;
    logic              w_alu_push;
    logic              w_md_push;
    logic              w_pop;
    logic [PW-1:0]     w_md_ptr;
    logic              w_hitA;
    logic              w_hitB;

    // Readiness looks only at registered occupancy; a same-cycle pop never frees a slot.
    assign w_alu_ready = (r_count < CW'(DEPTH));
    assign w_alu_acc   = bus.alu_valid & w_alu_ready;
    assign w_md_ready  = ((r_count + CW'(w_alu_acc)) < CW'(DEPTH));
    assign w_alu_push  = w_alu_acc & (bus.alu_reg != '0);
    assign w_md_push   = bus.md_valid & w_md_ready & (bus.md_reg != '0);
    assign w_pop       = (r_count != '0);
    assign w_md_ptr    = r_wptr + PW'(w_alu_push);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld   <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_wreg  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
        end else begin
            r_we <= w_pop;
            if (w_pop) begin
                r_wreg        <= r_reg[r_rptr];
                r_wdata       <= r_data[r_rptr];
                r_vld[r_rptr] <= 1'b0;
                r_rptr        <= r_rptr + 1'b1;
            end
            if (w_alu_push) begin
                r_reg[r_wptr]  <= bus.alu_reg;
                r_data[r_wptr] <= bus.alu_data;
                r_vld[r_wptr]  <= 1'b1;
            end
            if (w_md_push) begin
                r_reg[w_md_ptr]  <= bus.md_reg;
                r_data[w_md_ptr] <= bus.md_data;
                r_vld[w_md_ptr]  <= 1'b1;
            end
            r_wptr  <= r_wptr + PW'(w_alu_push) + PW'(w_md_push);
            r_count <= r_count + CW'(w_alu_push) + CW'(w_md_push) - CW'(w_pop);
        end
    end

    // A register stays busy until its write leaves the output stage.
    always_comb begin
        w_hitA = r_we & (r_wreg == bus.chk_regA);
        w_hitB = r_we & (r_wreg == bus.chk_regB);
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (r_vld[i] && r_reg[i] == bus.chk_regA) w_hitA = 1'b1;
            if (r_vld[i] && r_reg[i] == bus.chk_regB) w_hitB = 1'b1;
        end
    end

    assign bus.alu_ready = w_alu_ready;
    assign bus.md_ready  = w_md_ready;
    assign bus.writeReg  = r_wreg;
    assign bus.writeData = r_wdata;
    assign bus.RegWrite  = r_we;
    assign bus.count     = r_count;
    assign bus.busyA     = (bus.chk_regA != '0) & w_hitA;
    assign bus.busyB     = (bus.chk_regB != '0) & w_hitB;
endmodule

// File: tb/tb_regfile_wb_driver.sv
// Scoreboard bench for regfile_wb_driver: accepted writes are queued as they are driven and
// matched against each RegWrite pulse; occupancy and readiness follow a small reference count.
module tb_regfile_wb_driver;
    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    typedef struct packed {
        logic [ADDR_W-1:0] r;
        logic [DATA_W-1:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   m_cnt    = 0;
    logic m_we     = 1'b0;
    wr_t  sb[$];

    regfile_wb_driver_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) ifc ();

    regfile_wb_driver #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    always #5 clk = ~clk;

    // One clock: check readiness before the edge, update the reference, check outputs after it.
    task automatic step();
        logic a_acc, m_acc, pop;
        wr_t  got, exp;
        #1;
        a_acc = ifc.alu_valid && (m_cnt < DEPTH);
        m_acc = ifc.md_valid && (m_cnt + int'(a_acc) < DEPTH);
        checks++;
        if (ifc.alu_ready !== (m_cnt < DEPTH)) begin
            failures++;
            $display("FAIL alu_ready: got %b expected %b (count %0d)", ifc.alu_ready, (m_cnt < DEPTH), m_cnt);
        end
        checks++;
        if (ifc.md_ready !== (m_cnt + int'(ifc.alu_valid && m_cnt < DEPTH) < DEPTH)) begin
            failures++;
            $display("FAIL md_ready: got %b expected %b (count %0d)", ifc.md_ready, ~ifc.md_ready, m_cnt);
        end
        @(posedge clk);
        if (rst) begin
            sb.delete();
            m_cnt = 0;
            m_we  = 1'b0;
        end else begin
            pop  = (m_cnt > 0);
            m_we = pop;
            m_cnt = m_cnt - int'(pop);
            if (a_acc && ifc.alu_reg != 0) begin
                sb.push_back({ifc.alu_reg, ifc.alu_data});
                m_cnt++;
            end
            if (m_acc && ifc.md_reg != 0) begin
                sb.push_back({ifc.md_reg, ifc.md_data});
                m_cnt++;
            end
        end
        #1;
        checks++;
        if (ifc.count !== 3'(m_cnt)) begin
            failures++;
            $display("FAIL count: got %0d expected %0d", ifc.count, m_cnt);
        end
        checks++;
        if (ifc.RegWrite !== m_we) begin
            failures++;
            $display("FAIL regwrite_timing: got %b expected %b", ifc.RegWrite, m_we);
        end
        if (ifc.RegWrite === 1'b1) begin
            checks++;
            got = {ifc.writeReg, ifc.writeData};
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write: got r%0d=%0h expected no write", ifc.writeReg, ifc.writeData);
            end else begin
                exp = sb.pop_front();
                if (got !== exp) begin
                    failures++;
                    $display("FAIL retire: got r%0d=%0h expected r%0d=%0h", got.r, got.d, exp.r, exp.d);
                end
            end
        end
    endtask

    task automatic idle_inputs();
        ifc.alu_valid = 1'b0;
        ifc.md_valid  = 1'b0;
        ifc.alu_reg   = '0;
        ifc.md_reg    = '0;
        ifc.alu_data  = '0;
        ifc.md_data   = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        ifc.chk_regA = '0;
        ifc.chk_regB = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (ifc.count !== 3'd0 || ifc.RegWrite !== 1'b0 || ifc.writeReg !== 5'd0 || ifc.writeData !== 32'd0) begin
            failures++;
            $display("FAIL reset_state: got cnt=%0d we=%b reg=%0d data=%0h expected all zero",
                     ifc.count, ifc.RegWrite, ifc.writeReg, ifc.writeData);
        end
    endtask

    task automatic test_single_alu();
        ifc.chk_regA  = 5'd3;
        ifc.alu_valid = 1'b1;
        ifc.alu_reg   = 5'd3;
        ifc.alu_data  = 32'h28;
        step();
        idle_inputs();
        checks++;
        if (ifc.busyA !== 1'b1 || ifc.RegWrite !== 1'b0) begin
            failures++;
            $display("FAIL single_k: got busy=%b we=%b expected busy=1 we=0", ifc.busyA, ifc.RegWrite);
        end
        step();
        checks++;
        if (ifc.RegWrite !== 1'b1 || ifc.writeReg !== 5'd3 || ifc.writeData !== 32'h28 || ifc.busyA !== 1'b1) begin
            failures++;
            $display("FAIL single_k1: got we=%b r%0d=%0h busy=%b expected we=1 r3=28 busy=1",
                     ifc.RegWrite, ifc.writeReg, ifc.writeData, ifc.busyA);
        end
        step();
        checks++;
        if (ifc.RegWrite !== 1'b0 || ifc.busyA !== 1'b0) begin
            failures++;
            $display("FAIL single_k2: got we=%b busy=%b expected we=0 busy=0", ifc.RegWrite, ifc.busyA);
        end
    endtask

    task automatic test_simultaneous();
        ifc.chk_regA  = 5'd2;
        ifc.chk_regB  = 5'd5;
        ifc.alu_valid = 1'b1;
        ifc.alu_reg   = 5'd2;
        ifc.alu_data  = 32'd25;
        ifc.md_valid  = 1'b1;
        ifc.md_reg    = 5'd5;
        ifc.md_data   = 32'h1A3BEE22;
        step();
        idle_inputs();
        checks++;
        if (ifc.count !== 3'd2 || ifc.busyA !== 1'b1 || ifc.busyB !== 1'b1) begin
            failures++;
            $display("FAIL simul_accept: got cnt=%0d bA=%b bB=%b expected cnt=2 bA=1 bB=1",
                     ifc.count, ifc.busyA, ifc.busyB);
        end
        step();
        checks++;
        if (ifc.RegWrite !== 1'b1 || ifc.writeReg !== 5'd2 || ifc.writeData !== 32'd25) begin
            failures++;
            $display("FAIL simul_first: got we=%b r%0d=%0h expected we=1 r2=19", ifc.RegWrite, ifc.writeReg, ifc.writeData);
        end
        step();
        checks++;
        if (ifc.RegWrite !== 1'b1 || ifc.writeReg !== 5'd5 || ifc.writeData !== 32'h1A3BEE22) begin
            failures++;
            $display("FAIL simul_second: got we=%b r%0d=%0h expected we=1 r5=1a3bee22", ifc.RegWrite, ifc.writeReg, ifc.writeData);
        end
        step();
    endtask

    task automatic test_fill();
        for (int i = 0; i < 8; i++) begin
            ifc.alu_valid = 1'b1;
            ifc.alu_reg   = 5'(2 * i % 31 + 1);
            ifc.alu_data  = $urandom;
            ifc.md_valid  = 1'b1;
            ifc.md_reg    = 5'((2 * i + 1) % 31 + 1);
            ifc.md_data   = $urandom;
            step();
            checks++;
            if (ifc.count > 3'(DEPTH)) begin
                failures++;
                $display("FAIL fill_bound: got cnt=%0d expected <= %0d", ifc.count, DEPTH);
            end
            if (ifc.count == 3'(DEPTH)) begin
                checks++;
                if (ifc.alu_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL full_ready: got %b expected 0", ifc.alu_ready);
                end
            end
            if (ifc.count == 3'd3) begin
                checks++;
                if (ifc.md_ready !== 1'b0 || ifc.alu_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL cnt3_ready: got alu=%b md=%b expected alu=1 md=0", ifc.alu_ready, ifc.md_ready);
                end
            end
        end
        idle_inputs();
        for (int i = 0; i < 5; i++) step();
    endtask

    task automatic test_reg0();
        ifc.chk_regA  = 5'd0;
        ifc.alu_valid = 1'b1;
        ifc.alu_reg   = 5'd0;
        ifc.alu_data  = 32'hFFFFFFFF;
        #1;
        checks++;
        if (ifc.alu_ready !== 1'b1 || ifc.busyA !== 1'b0) begin
            failures++;
            $display("FAIL reg0_pre: got ready=%b busy=%b expected ready=1 busy=0", ifc.alu_ready, ifc.busyA);
        end
        step();
        idle_inputs();
        checks++;
        if (ifc.count !== 3'd0 || ifc.busyA !== 1'b0) begin
            failures++;
            $display("FAIL reg0_post: got cnt=%0d busy=%b expected cnt=0 busy=0", ifc.count, ifc.busyA);
        end
        step();
        checks++;
        if (ifc.RegWrite !== 1'b0) begin
            failures++;
            $display("FAIL reg0_write: got we=%b expected 0", ifc.RegWrite);
        end
    endtask

    task automatic test_same_reg();
        logic [DATA_W-1:0] exp_d [2];
        exp_d[0] = 32'd1;
        exp_d[1] = 32'd2;
        ifc.chk_regA  = 5'd7;
        ifc.alu_valid = 1'b1;
        ifc.alu_reg   = 5'd7;
        ifc.alu_data  = 32'd1;
        step();
        ifc.alu_data  = 32'd2;
        step();
        idle_inputs();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (ifc.RegWrite !== 1'b1 || ifc.writeReg !== 5'd7 || ifc.writeData !== exp_d[i] || ifc.busyA !== 1'b1) begin
                failures++;
                $display("FAIL same_reg_%0d: got we=%b r%0d=%0h busy=%b expected we=1 r7=%0h busy=1",
                         i, ifc.RegWrite, ifc.writeReg, ifc.writeData, ifc.busyA, exp_d[i]);
            end
            step();
        end
        checks++;
        if (ifc.RegWrite !== 1'b0 || ifc.busyA !== 1'b0) begin
            failures++;
            $display("FAIL same_reg_done: got we=%b busy=%b expected we=0 busy=0", ifc.RegWrite, ifc.busyA);
        end
    endtask

    task automatic test_reset_mid();
        ifc.alu_valid = 1'b1;
        ifc.alu_reg   = 5'd9;
        ifc.alu_data  = 32'hA;
        ifc.md_valid  = 1'b1;
        ifc.md_reg    = 5'd10;
        ifc.md_data   = 32'hB;
        step();
        ifc.alu_reg   = 5'd11;
        ifc.md_reg    = 5'd12;
        step();
        checks++;
        if (ifc.count !== 3'd3 || ifc.RegWrite !== 1'b1) begin
            failures++;
            $display("FAIL mid_setup: got cnt=%0d we=%b expected cnt=3 we=1", ifc.count, ifc.RegWrite);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle_inputs();
        checks++;
        if (ifc.count !== 3'd0 || ifc.RegWrite !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: got cnt=%0d we=%b expected cnt=0 we=0", ifc.count, ifc.RegWrite);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (ifc.RegWrite !== 1'b0) begin
                failures++;
                $display("FAIL mid_after_%0d: got we=%b expected 0", i, ifc.RegWrite);
            end
        end
    endtask

    initial begin
        idle_inputs();
        ifc.chk_regA = '0;
        ifc.chk_regB = '0;
        test_reset();
        test_single_alu();
        test_simultaneous();
        test_fill();
        test_reg0();
        test_same_reg();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/regfile_wb_driver.md
Name: regfile_wb_driver

Overview:
- Write-side initiator for the register file's single write port (writeReg / writeData / RegWrite).
- Accepts writeback requests from two producers: the single-cycle ALU path and the multi-cycle multiply/divide unit.
- Queues requests in a small in-order FIFO and retires one write per clock to the register file.
- Reports per-register "write pending" status so the hazard unit can stall dependent reads.

Parameters:
- DEPTH, 4, number of FIFO entries (power of 2, >= 2)
- DATA_W, 32, write data width
- ADDR_W, 5, register index width

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- alu_valid  in  1  ALU writeback request
- alu_ready  out  1  ALU request accepted this cycle
- alu_reg  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- md_valid  in  1  mul/div writeback request
- md_ready  out  1  mul/div request accepted this cycle
- md_reg  in  ADDR_W  mul/div destination register
- md_data  in  DATA_W  mul/div result
- writeReg  out  ADDR_W  to register file write index
- writeData  out  DATA_W  to register file write data
- RegWrite  out  1  to register file write enable
- chk_regA  in  ADDR_W  source register A under hazard check
- chk_regB  in  ADDR_W  source register B under hazard check
- busyA  out  1  chk_regA has a write not yet committed
- busyB  out  1  chk_regB has a write not yet committed
- count  out  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset, sampled at posedge with rst=1:
  - count=0; FIFO empty.
  - writeReg=0, writeData=0, RegWrite=0.
  - Takes effect mid-operation too: all queued and in-flight writes are discarded; nothing is emitted afterwards.
- Ready rules are combinational and depend on registered count only, never on the same-cycle pop:
  - alu_ready = (count < DEPTH).
  - md_ready = (count + (alu_valid & alu_ready) < DEPTH).
- Accept = valid & ready, per source.
- Enqueue order on simultaneous accept: ALU entry first, then mul/div entry. Both land in the same cycle and count rises by 2.
- Register 0:
  - A request with reg==0 is accepted (ready honoured) but not enqueued.
  - It never produces RegWrite and never sets busy.
- Pop: at each posedge with count>0 (before this edge's pushes), the head entry is removed and loaded into the output register. That edge sets RegWrite=1, writeReg=head.reg, writeData=head.data.
- If count==0 at the edge, RegWrite is set to 0. writeReg and writeData hold their last values.
- Latency: a request accepted at edge k into an empty FIFO is popped at edge k+1. RegWrite is high for the cycle between k+1 and k+2, and the register file commits at edge k+2.
- Simultaneous push and pop in the same edge: count_next = count + pushes - pop.
- Pointers wrap modulo DEPTH.
- A full FIFO that pops still reports ready=0 in that cycle (no same-cycle slot reuse).
- Writes retire strictly in acceptance order. Two pending writes to the same register are both emitted, and the later one wins in the register file.
- Busy (combinational from registered state):
  - busyA = (chk_regA != 0) & (chk_regA matches any valid FIFO entry, OR (RegWrite==1 & writeReg==chk_regA)).
  - busyB is identical, using chk_regB.
  - Busy does not consider same-cycle incoming requests.
- A write with an unknown destination register is never generated; the outputs are always fully defined after reset.

Test Plan:
- Reset then single ALU write: alu_valid=1, reg=3, data=0x28 at edge k. Required: RegWrite=1, writeReg=3, writeData=0x28 after edge k+1; RegWrite=0 after k+2; busyA(chk=3)=1 from k through k+2 and 0 after.
- Simultaneous sources into empty FIFO: ALU (r2=25) and MD (r5=0x1A3BEE22) at one edge. Required: count=2; retire order r2, then r5 on consecutive cycles.
- Fill to full:
  - Present alu_valid=md_valid=1 every cycle. Required: count never exceeds 4, and alu_ready=0 whenever count==4.
  - With count==3, alu_valid=1 and md_valid=1. Required: md_ready=0.
- Register 0 filtering: ALU write r0=0xFFFFFFFF. Required: alu_ready=1, count unchanged, RegWrite never asserts for it, busy(chk=0)=0.
- Same-register ordering: back-to-back ALU writes to r7 with 1 then 2. Required: two RegWrite pulses in order 1, 2; busyA(chk=7) stays 1 until the second retires.
- Reset mid-operation: with count=3 and RegWrite=1, assert rst for one edge. Required: count=0 and RegWrite=0 next cycle, with no further writes emitted.
